// File: rtl/trap_control_unit_pkg.sv
// Shared types and constants for the trap control unit: FSM encoding, mcause codes and
// the default handler entry address.
package trap_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAP,
    ST_HANDLER,
    ST_RETURN,
    ST_HALT
  } state_e;

  localparam logic [31:0] CAUSE_ADDR_FAULT   = 32'd5;
  localparam logic [31:0] CAUSE_ILLEGAL      = 32'd2;
  localparam logic [31:0] CAUSE_ECALL        = 32'd11;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

  typedef struct packed {
    logic        hit;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
  } trap_sel_t;

endpackage

// File: rtl/trap_control_unit_priority_encoder.sv
// Combinational trap-source arbiter: picks cause, mepc and mtval for the highest-priority
// pending source and flags a clean MRET that has no competing trap.
module trap_priority_encoder
  import trap_control_unit_pkg::*;
(
  input  logic        in_idle,
  input  logic        address_exception,
  input  logic        instr_valid,
  input  logic        illegal_instr,
  input  logic        ecall_instr,
  input  logic        mret_instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc_dly,
  input  logic [31:0] addr_dly,
  output trap_sel_t   sel,
  output logic        mret_take
);

  logic illegal_eff;

  // Outside a handler there is nothing to return from, so MRET counts as an illegal instruction.
  assign illegal_eff = instr_valid & (illegal_instr | (mret_instr & in_idle));

  always_comb begin
    sel       = '0;
    mret_take = 1'b0;
    // The address flag belongs to the previous instruction, so it is not gated by instr_valid.
    if (address_exception) begin
      sel.hit   = 1'b1;
      sel.cause = CAUSE_ADDR_FAULT;
      sel.epc   = pc_dly;
      sel.tval  = addr_dly;
    end else if (illegal_eff) begin
      sel.hit   = 1'b1;
      sel.cause = CAUSE_ILLEGAL;
      sel.epc   = pc;
    end else if (instr_valid && ecall_instr) begin
      sel.hit   = 1'b1;
      sel.cause = CAUSE_ECALL;
      sel.epc   = pc;
    end else if (instr_valid && mret_instr && !in_idle) begin
      mret_take = 1'b1;
    end
  end

endmodule

// File: rtl/trap_control_unit.sv
// Machine-mode trap controller: takes exceptions into a fixed handler vector, returns on MRET,
// and halts on a fault raised while already inside the handler.
module trap_control_unit
  import trap_control_unit_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
  parameter int unsigned ADDR_LIMIT  = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic [31:0] mem_address,
  input  logic        address_exception,
  input  logic        illegal_instr,
  input  logic        ecall_instr,
  input  logic        mret_instr,
  output logic        exception_sig,
  output logic        mret_sig,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        in_handler,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [31:0] pc_dly_q, pc_dly_d, addr_dly_q, addr_dly_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        exception_sig_q, exception_sig_d, mret_sig_q, mret_sig_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic        in_handler_q, in_handler_d, halted_q, halted_d;

  trap_sel_t   sel;
  logic        mret_take;

  trap_priority_encoder u_prio (
    .in_idle          (state_q == ST_IDLE),
    .address_exception(address_exception),
    .instr_valid      (instr_valid),
    .illegal_instr    (illegal_instr),
    .ecall_instr      (ecall_instr),
    .mret_instr       (mret_instr),
    .pc               (pc),
    .pc_dly           (pc_dly_q),
    .addr_dly         (addr_dly_q),
    .sel              (sel),
    .mret_take        (mret_take)
  );

  always_comb begin
    state_d          = state_q;
    pc_dly_d         = pc_dly_q;
    addr_dly_d       = addr_dly_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    exception_sig_d  = 1'b0;
    mret_sig_d       = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    in_handler_d     = in_handler_q;
    halted_d         = halted_q;
    // Inputs are only sampled in IDLE/HANDLER; TRAP and RETURN see stale flags from the pipeline.
    if ((state_q == ST_IDLE || state_q == ST_HANDLER) && instr_valid) begin
      pc_dly_d   = pc;
      addr_dly_d = mem_address;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (sel.hit) begin
          state_d          = ST_TRAP;
          mepc_d           = sel.epc;
          mcause_d         = sel.cause;
          mtval_d          = sel.tval;
          exception_sig_d  = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = TRAP_VECTOR;
        end
      end
      ST_TRAP: begin
        state_d      = ST_HANDLER;
        in_handler_d = 1'b1;
      end
      ST_HANDLER: begin
        if (sel.hit) begin
          state_d      = ST_HALT;
          in_handler_d = 1'b0;
          halted_d     = 1'b1;
        end else if (mret_take) begin
          state_d          = ST_RETURN;
          in_handler_d     = 1'b0;
          mret_sig_d       = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = mepc_q + 32'd4;
        end
      end
      ST_RETURN: state_d = ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      pc_dly_q         <= '0;
      addr_dly_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      redirect_pc_q    <= '0;
      exception_sig_q  <= 1'b0;
      mret_sig_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      in_handler_q     <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_dly_q         <= pc_dly_d;
      addr_dly_q       <= addr_dly_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      redirect_pc_q    <= redirect_pc_d;
      exception_sig_q  <= exception_sig_d;
      mret_sig_q       <= mret_sig_d;
      redirect_valid_q <= redirect_valid_d;
      in_handler_q     <= in_handler_d;
      halted_q         <= halted_d;
    end
  end

  assign exception_sig  = exception_sig_q;
  assign mret_sig       = mret_sig_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign mepc           = mepc_q;
  assign mcause         = mcause_q;
  assign mtval          = mtval_q;
  assign in_handler     = in_handler_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_trap_control_unit.sv
// Directed bench for trap_control_unit: expected output snapshots are queued with each
// stimulus step and compared one cycle later, after the clock edge that produces them.
module tb_trap_control_unit;
  import trap_control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] mem_address = '0;
  logic        address_exception = 1'b0;
  logic        illegal_instr = 1'b0;
  logic        ecall_instr = 1'b0;
  logic        mret_instr = 1'b0;
  logic        exception_sig, mret_sig, redirect_valid, in_handler, halted;
  logic [31:0] redirect_pc, mepc, mcause, mtval;

  typedef struct {
    string       tag;
    logic        exc;
    logic        mrs;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] tval;
    logic        inh;
    logic        hlt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  trap_control_unit dut (
    .clk              (clk),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .pc               (pc),
    .mem_address      (mem_address),
    .address_exception(address_exception),
    .illegal_instr    (illegal_instr),
    .ecall_instr      (ecall_instr),
    .mret_instr       (mret_instr),
    .exception_sig    (exception_sig),
    .mret_sig         (mret_sig),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .mepc             (mepc),
    .mcause           (mcause),
    .mtval            (mtval),
    .in_handler       (in_handler),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string field, input logic [31:0] obs,
                     input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic exc, input logic mrs, input logic rv,
                              input logic [31:0] rpc, input logic [31:0] epc,
                              input logic [31:0] cause, input logic [31:0] tval,
                              input logic inh, input logic hlt);
    exp_t e;
    e.tag = tag; e.exc = exc; e.mrs = mrs; e.rv = rv; e.rpc = rpc;
    e.epc = epc; e.cause = cause; e.tval = tval; e.inh = inh; e.hlt = hlt;
    return e;
  endfunction

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "exception_sig", {31'd0, exception_sig}, {31'd0, e.exc});
    cmp(e.tag, "mret_sig", {31'd0, mret_sig}, {31'd0, e.mrs});
    cmp(e.tag, "redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
    cmp(e.tag, "redirect_pc", redirect_pc, e.rpc);
    cmp(e.tag, "mepc", mepc, e.epc);
    cmp(e.tag, "mcause", mcause, e.cause);
    cmp(e.tag, "mtval", mtval, e.tval);
    cmp(e.tag, "in_handler", {31'd0, in_handler}, {31'd0, e.inh});
    cmp(e.tag, "halted", {31'd0, halted}, {31'd0, e.hlt});
  endtask

  task automatic drive(input logic iv, input logic [31:0] p, input logic [31:0] a,
                       input logic ae, input logic il, input logic ec, input logic mr);
    instr_valid = iv; pc = p; mem_address = a;
    address_exception = ae; illegal_instr = il; ecall_instr = ec; mret_instr = mr;
  endtask

  task automatic tick(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    sb.push_back(mk("reset", 0, 0, 0, '0, '0, '0, '0, 0, 0));
    check_now();
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Delayed address fault, with an address above ADDR_LIMIT that must not be clamped.
    drive(1, 32'h40, 32'h1400, 0, 0, 0, 0);
    tick(mk("addr_issue", 0, 0, 0, '0, '0, '0, '0, 0, 0));
    drive(0, 32'h44, '0, 1, 0, 0, 0);
    tick(mk("addr_trap", 1, 0, 1, TRAP_VECTOR_DEFAULT, 32'h40, 32'd5, 32'h1400, 0, 0));
    drive(1, 32'h48, 32'h10, 1, 1, 0, 0);
    tick(mk("addr_handler", 0, 0, 0, '0, 32'h40, 32'd5, 32'h1400, 1, 0));
    drive(1, 32'h100, '0, 0, 0, 0, 1);
    tick(mk("addr_return", 0, 1, 1, 32'h44, 32'h40, 32'd5, 32'h1400, 0, 0));
    drive(1, 32'h200, '0, 1, 1, 0, 0);
    tick(mk("addr_idle", 0, 0, 0, '0, 32'h40, 32'd5, 32'h1400, 0, 0));

    // ECALL round trip.
    drive(1, 32'h80, 32'h5, 0, 0, 1, 0);
    tick(mk("ecall_trap", 1, 0, 1, TRAP_VECTOR_DEFAULT, 32'h80, 32'd11, '0, 0, 0));
    drive(0, '0, '0, 0, 0, 0, 0);
    tick(mk("ecall_handler", 0, 0, 0, '0, 32'h80, 32'd11, '0, 1, 0));
    drive(1, 32'h104, '0, 0, 0, 0, 1);
    tick(mk("ecall_return", 0, 1, 1, 32'h84, 32'h80, 32'd11, '0, 0, 0));
    drive(0, '0, '0, 0, 0, 0, 0);
    tick(mk("ecall_idle", 0, 0, 0, '0, 32'h80, 32'd11, '0, 0, 0));

    // Illegal beats ECALL; the held request must not raise a second pulse.
    drive(1, 32'h10, '0, 0, 1, 1, 0);
    tick(mk("prio_trap", 1, 0, 1, TRAP_VECTOR_DEFAULT, 32'h10, 32'd2, '0, 0, 0));
    tick(mk("prio_handler", 0, 0, 0, '0, 32'h10, 32'd2, '0, 1, 0));
    drive(1, 32'h108, '0, 0, 0, 0, 1);
    tick(mk("prio_return", 0, 1, 1, 32'h14, 32'h10, 32'd2, '0, 0, 0));
    drive(0, '0, '0, 0, 0, 0, 0);
    tick(mk("prio_idle", 0, 0, 0, '0, 32'h10, 32'd2, '0, 0, 0));

    // MRET outside a handler is illegal.
    drive(1, 32'h20, '0, 0, 0, 0, 1);
    tick(mk("mret_idle_trap", 1, 0, 1, TRAP_VECTOR_DEFAULT, 32'h20, 32'd2, '0, 0, 0));
    drive(0, '0, '0, 0, 0, 0, 0);
    tick(mk("mret_idle_handler", 0, 0, 0, '0, 32'h20, 32'd2, '0, 1, 0));
    drive(1, 32'h10c, '0, 0, 0, 0, 1);
    tick(mk("mret_idle_return", 0, 1, 1, 32'h24, 32'h20, 32'd2, '0, 0, 0));
    drive(0, '0, '0, 0, 0, 0, 0);
    tick(mk("mret_idle_idle", 0, 0, 0, '0, 32'h20, 32'd2, '0, 0, 0));

    // Nested illegal inside handler halts and keeps the ECALL CSRs.
    drive(1, 32'h50, '0, 0, 0, 1, 0);
    tick(mk("nest_trap", 1, 0, 1, TRAP_VECTOR_DEFAULT, 32'h50, 32'd11, '0, 0, 0));
    drive(0, '0, '0, 0, 0, 0, 0);
    tick(mk("nest_handler", 0, 0, 0, '0, 32'h50, 32'd11, '0, 1, 0));
    drive(1, 32'h60, '0, 0, 1, 0, 0);
    tick(mk("nest_halt", 0, 0, 0, '0, 32'h50, 32'd11, '0, 0, 1));
    drive(1, 32'h64, '0, 0, 0, 0, 1);
    tick(mk("halt_mret", 0, 0, 0, '0, 32'h50, 32'd11, '0, 0, 1));
    drive(1, 32'h68, 32'h9, 1, 0, 1, 0);
    tick(mk("halt_sticky", 0, 0, 0, '0, 32'h50, 32'd11, '0, 0, 1));

    // Address fault coinciding with MRET in the handler halts instead of returning.
    do_reset();
    drive(1, 32'h70, '0, 0, 0, 1, 0);
    tick(mk("amret_trap", 1, 0, 1, TRAP_VECTOR_DEFAULT, 32'h70, 32'd11, '0, 0, 0));
    drive(0, '0, '0, 0, 0, 0, 0);
    tick(mk("amret_handler", 0, 0, 0, '0, 32'h70, 32'd11, '0, 1, 0));
    drive(1, 32'h74, 32'h200, 0, 0, 0, 0);
    tick(mk("amret_load", 0, 0, 0, '0, 32'h70, 32'd11, '0, 1, 0));
    drive(1, 32'h78, '0, 1, 0, 0, 1);
    tick(mk("amret_halt", 0, 0, 0, '0, 32'h70, 32'd11, '0, 0, 1));

    // Reset asserted between edges while TRAP is active.
    do_reset();
    drive(1, 32'h8, '0, 0, 0, 1, 0);
    tick(mk("abort_trap", 1, 0, 1, TRAP_VECTOR_DEFAULT, 32'h8, 32'd11, '0, 0, 0));
    drive(0, '0, '0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    sb.push_back(mk("abort_now", 0, 0, 0, '0, '0, '0, '0, 0, 0));
    check_now();
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(mk("abort_after", 0, 0, 0, '0, '0, '0, '0, 0, 0));
    check_now();
    tick(mk("abort_idle", 0, 0, 0, '0, '0, '0, '0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
